// File: rtl/alu_rs_pkg.sv
// Shared types, default sizes and helpers for the ALU reservation-station
// select stage and its round-robin arbiter.
package alu_rs_pkg;

    localparam int ENTRIES_DEF = 4;
    localparam int WIDTH_DEF   = 31;
    localparam int ROB_DEF     = 2;
    localparam int C_WIDTH_DEF = 3;

    // Widest request vector the index helper can encode.
    localparam int MAX_ENTRIES = 32;
    localparam int MAX_IDX_W   = 5;

    // One issued ALU operation at the default sizes.
    typedef struct packed {
        logic signed [WIDTH_DEF:0] src1;
        logic signed [WIDTH_DEF:0] src2;
        logic [C_WIDTH_DEF:0]      ctrl;
        logic [ROB_DEF:0]          rob;
    } alu_issue_t;

    // Encode a one-hot (or all-zero) vector into a binary index.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_ENTRIES-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_rs_select_if.sv
// Issue handshake between the select stage (master) and the ALU (slave).
interface alu_rs_select_if #(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int C_WIDTH = 3
);
    logic                issueValid;
    logic                issueReady;
    logic signed [WIDTH:0] issueSrc1;
    logic signed [WIDTH:0] issueSrc2;
    logic [C_WIDTH:0]    issueCtrl;
    logic [ROB:0]        issueRob;

    modport master (
        output issueValid,
        output issueSrc1,
        output issueSrc2,
        output issueCtrl,
        output issueRob,
        input  issueReady
    );

    modport slave (
        input  issueValid,
        input  issueSrc1,
        input  issueSrc2,
        input  issueCtrl,
        input  issueRob,
        output issueReady
    );
endinterface

// File: rtl/alu_rs_select_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around. Shared with other issue selectors.
module rr_arbiter
    import alu_rs_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    localparam int PTR_W  = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [ENTRIES-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // Walk the entries starting at the pointer; the first requester wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = pointer;
        for (int k = 0; k < ENTRIES; k++) begin
            idx_s = pointer + PTR_W'(k);
            if (req[idx_s] && !found_s) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant_idx = PTR_W'(onehot_to_idx(MAX_ENTRIES'(grant)));

endmodule

// File: rtl/alu_rs_select.sv
// ALU reservation-station select/issue stage: picks one requesting entry per
// cycle in round-robin order, latches its payload into the issue register,
// and pulses that entry's clear line.
module alu_rs_select
    import alu_rs_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ROB     = ROB_DEF,
    parameter int C_WIDTH = C_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [ENTRIES-1:0]             selectReq,
    input  logic [ENTRIES*(WIDTH+1)-1:0]   src1,
    input  logic [ENTRIES*(WIDTH+1)-1:0]   src2,
    input  logic [ENTRIES*(C_WIDTH+1)-1:0] instrInfo,
    input  logic [ENTRIES*(ROB+1)-1:0]     instrRob,
    output logic [ENTRIES-1:0]             clear,
    alu_rs_select_if.master                iss
);

    localparam int PTR_W = $clog2(ENTRIES);

    // Registered state
    logic                  valid_r;
    logic signed [WIDTH:0] src1_r;
    logic signed [WIDTH:0] src2_r;
    logic [C_WIDTH:0]      ctrl_r;
    logic [ROB:0]          rob_r;
    logic [ENTRIES-1:0]    clear_r;
    logic [ENTRIES-1:0]    mask_r;
    logic [PTR_W-1:0]      ptr_r;

    // Next-state values
    logic                  valid_nxt_s;
    logic signed [WIDTH:0] src1_nxt_s;
    logic signed [WIDTH:0] src2_nxt_s;
    logic [C_WIDTH:0]      ctrl_nxt_s;
    logic [ROB:0]          rob_nxt_s;
    logic [ENTRIES-1:0]    clear_nxt_s;
    logic [ENTRIES-1:0]    mask_nxt_s;
    logic [PTR_W-1:0]      ptr_nxt_s;

    // Selection
    logic                  fire_s;
    logic                  free_s;
    logic                  grant_en_s;
    logic [ENTRIES-1:0]    req_s;
    logic [ENTRIES-1:0]    grant_s;
    logic [PTR_W-1:0]      grant_idx_s;
    logic signed [WIDTH:0] sel_src1_s;
    logic signed [WIDTH:0] sel_src2_s;
    logic [C_WIDTH:0]      sel_ctrl_s;
    logic [ROB:0]          sel_rob_s;

    // The entry granted last cycle still shows its request for one more
    // cycle before its busy bit drops, so it is masked out here.
    assign req_s      = selectReq & ~mask_r;
    assign fire_s     = valid_r & iss.issueReady;
    assign free_s     = ~valid_r | iss.issueReady;
    assign grant_en_s = free_s & (|req_s) & ~flush;

    rr_arbiter #(.ENTRIES(ENTRIES)) u_arb (
        .req       (req_s),
        .pointer   (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Route the granted entry's payload out of the packed entry buses.
    always_comb begin
        sel_src1_s = src1[int'(grant_idx_s)*(WIDTH+1) +: (WIDTH+1)];
        sel_src2_s = src2[int'(grant_idx_s)*(WIDTH+1) +: (WIDTH+1)];
        sel_ctrl_s = instrInfo[int'(grant_idx_s)*(C_WIDTH+1) +: (C_WIDTH+1)];
        sel_rob_s  = instrRob[int'(grant_idx_s)*(ROB+1) +: (ROB+1)];
    end

    // Next-state: flush drops the op, a grant loads a new one (possibly
    // back-to-back with a fire), a plain fire empties the register.
    always_comb begin
        valid_nxt_s = valid_r;
        src1_nxt_s  = src1_r;
        src2_nxt_s  = src2_r;
        ctrl_nxt_s  = ctrl_r;
        rob_nxt_s   = rob_r;
        clear_nxt_s = '0;
        mask_nxt_s  = '0;
        ptr_nxt_s   = ptr_r;
        if (flush) begin
            valid_nxt_s = 1'b0;
            src1_nxt_s  = '0;
            src2_nxt_s  = '0;
            ctrl_nxt_s  = '0;
            rob_nxt_s   = '0;
        end else if (grant_en_s) begin
            valid_nxt_s = 1'b1;
            src1_nxt_s  = sel_src1_s;
            src2_nxt_s  = sel_src2_s;
            ctrl_nxt_s  = sel_ctrl_s;
            rob_nxt_s   = sel_rob_s;
            clear_nxt_s = grant_s;
            mask_nxt_s  = grant_s;
            ptr_nxt_s   = grant_idx_s + PTR_W'(1);
        end else if (fire_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            src1_r  <= '0;
            src2_r  <= '0;
            ctrl_r  <= '0;
            rob_r   <= '0;
            clear_r <= '0;
            mask_r  <= '0;
            ptr_r   <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            src1_r  <= src1_nxt_s;
            src2_r  <= src2_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
            rob_r   <= rob_nxt_s;
            clear_r <= clear_nxt_s;
            mask_r  <= mask_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    assign iss.issueValid = valid_r;
    assign iss.issueSrc1  = src1_r;
    assign iss.issueSrc2  = src2_r;
    assign iss.issueCtrl  = ctrl_r;
    assign iss.issueRob   = rob_r;
    assign clear          = clear_r;

endmodule

// File: tb/tb_alu_rs_select.sv
// Directed, table-driven bench for alu_rs_select (4 entries, 32-bit operands).
module tb_alu_rs_select;
    import alu_rs_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic [3:0]   sel;
    logic [127:0] s1;
    logic [127:0] s2;
    logic [15:0]  info;
    logic [11:0]  robv;
    logic [3:0]   clear;

    int checks = 0;
    int errors = 0;

    alu_issue_t ent [4];

    typedef struct {
        logic       flush;
        logic [3:0] sel;
        logic       ready;
        logic       exp_valid;
        logic [3:0] exp_clear;
        int         exp_entry;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs [$];

    alu_rs_select_if #(.WIDTH(31), .ROB(2), .C_WIDTH(3)) iss_if ();

    alu_rs_select #(.ENTRIES(4), .WIDTH(31), .ROB(2), .C_WIDTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .selectReq (sel),
        .src1      (s1),
        .src2      (s2),
        .instrInfo (info),
        .instrRob  (robv),
        .clear     (clear),
        .iss       (iss_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic f, input logic [3:0] s, input logic r, input logic ev,
                       input logic [3:0] ec, input int ee, input logic [1:0] ep);
        vec_t v;
        v.flush     = f;
        v.sel       = s;
        v.ready     = r;
        v.exp_valid = ev;
        v.exp_clear = ec;
        v.exp_entry = ee;
        v.exp_ptr   = ep;
        vecs.push_back(v);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(iss_if.issueValid), 32'd0);
        chk({tag, ".clear"}, 32'(clear), 32'd0);
        chk({tag, ".src1"}, iss_if.issueSrc1, 32'd0);
        chk({tag, ".src2"}, iss_if.issueSrc2, 32'd0);
        chk({tag, ".ctrl"}, 32'(iss_if.issueCtrl), 32'd0);
        chk({tag, ".rob"}, 32'(iss_if.issueRob), 32'd0);
        chk({tag, ".ptr"}, 32'(dut.ptr_r), 32'd0);
    endtask

    initial begin
        ent[0] = '{src1: 32'sd100, src2: -32'sd100,  ctrl: 4'h1, rob: 3'd1};
        ent[1] = '{src1: 32'sd200, src2: -32'sd200,  ctrl: 4'h7, rob: 3'd3};
        ent[2] = '{src1: 32'sd5,   src2: -32'sd3,    ctrl: 4'h2, rob: 3'd6};
        ent[3] = '{src1: -32'sd7,  src2: 32'sd40000, ctrl: 4'hF, rob: 3'd7};
        for (int i = 0; i < 4; i++) begin
            s1[i*32 +: 32]  = ent[i].src1;
            s2[i*32 +: 32]  = ent[i].src2;
            info[i*4 +: 4]  = ent[i].ctrl;
            robv[i*3 +: 3]  = ent[i].rob;
        end

        reset = 1'b1;
        flush = 1'b0;
        sel   = 4'b0000;
        iss_if.issueReady = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;

        //   flush sel      rdy  valid clear   entry ptr
        add(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100,  2, 2'd3); // single request, entry 2
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, -1, 2'd3); // fire, nothing new
        add(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001,  0, 2'd1); // wrap from pointer 3 to entry 0
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, -1, 2'd1);
        add(1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000,  3, 2'd0); // bring pointer back to 0
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, -1, 2'd0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001,  0, 2'd1); // all request: 0,1,2,3,0
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010,  1, 2'd2);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100,  2, 2'd3);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000,  3, 2'd0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001,  0, 2'd1);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, -1, 2'd1); // stale request masked
        add(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001,  0, 2'd1); // mask gone, re-granted
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, -1, 2'd1);
        add(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100,  2, 2'd3); // load, ALU not ready
        add(1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000,  2, 2'd3); // stall x3: hold payload
        add(1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000,  2, 2'd3);
        add(1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000,  2, 2'd3);
        add(1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010,  1, 2'd2); // fire + back-to-back entry 1
        add(1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, -1, 2'd2); // flush drops the op
        add(1'b0, 4'b1000, 1'b0, 1'b1, 4'b1000,  3, 2'd0); // entry 3 issues after flush
        add(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, -1, 2'd0); // flush coinciding with fire
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, -1, 2'd0); // not re-issued
        add(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100,  2, 2'd3); // valid op for reset test

        for (int i = 0; i < vecs.size(); i++) begin
            flush = vecs[i].flush;
            sel   = vecs[i].sel;
            iss_if.issueReady = vecs[i].ready;
            tick();
            chk($sformatf("v%0d.valid", i), 32'(iss_if.issueValid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d.clear", i), 32'(clear), 32'(vecs[i].exp_clear));
            chk($sformatf("v%0d.ptr", i), 32'(dut.ptr_r), 32'(vecs[i].exp_ptr));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d.src1", i), iss_if.issueSrc1, ent[vecs[i].exp_entry].src1);
                chk($sformatf("v%0d.src2", i), iss_if.issueSrc2, ent[vecs[i].exp_entry].src2);
                chk($sformatf("v%0d.ctrl", i), 32'(iss_if.issueCtrl), 32'(ent[vecs[i].exp_entry].ctrl));
                chk($sformatf("v%0d.rob", i), 32'(iss_if.issueRob), 32'(ent[vecs[i].exp_entry].rob));
            end
        end

        // Reset while an op is held under back-pressure with a request pending.
        flush = 1'b0;
        sel   = 4'b0100;
        iss_if.issueReady = 1'b0;
        reset = 1'b1;
        tick();
        chk_zero("midreset");
        reset = 1'b0;
        sel   = 4'b0000;
        tick();
        chk("postreset.valid", 32'(iss_if.issueValid), 32'd0);
        chk("postreset.clear", 32'(clear), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
